// File: rtl/downstream_cancel_tracker.sv
// Per-client cancelled-quantity table updated by a three-state report sequencer (IDLE/READ/WRITE).
// The registered query port forwards the value being written this cycle.
module downstream_cancel_tracker #(
    parameter int unsigned NUM_CLIENTS = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             HRESETn,
    input  logic             rpt_valid,
    output logic             rpt_ready,
    input  logic [4:0]       rpt_client,
    input  logic [15:0]      rpt_amount,
    input  logic             rpt_clear,
    input  logic [4:0]       qry_client,
    output logic [CNT_W-1:0] qry_cancelled,
    output logic [15:0]      rpt_count,
    output logic             sat_flag,
    output logic             err_flag
);

    localparam int unsigned ID_W  = 5;
    localparam int unsigned AMT_W = 16;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   accept_c;

    logic [CNT_W-1:0] tbl [NUM_CLIENTS];
    logic [ID_W-1:0]  cl_q;
    logic [AMT_W-1:0] amt_q;
    logic             clr_q;
    logic [CNT_W-1:0] old_q;

    logic             cl_in_range_c;
    logic [CNT_W-1:0] rd_old_c;
    logic [CNT_W-1:0] rd_qry_c;
    logic [SUM_W-1:0] sum_c;
    logic             ovf_c;
    logic [CNT_W-1:0] new_c;
    logic             wr_en_c;
    logic [CNT_W-1:0] qry_next_c;

    // State register
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; ready is gated by reset so nothing is taken while held
    always_comb begin
        state_d   = state_q;
        rpt_ready = 1'b0;
        accept_c  = 1'b0;
        case (state_q)
            IDLE: begin
                rpt_ready = HRESETn;
                accept_c  = rpt_valid & HRESETn;
                if (accept_c) begin
                    state_d = READ;
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Table read ports; an out-of-range id matches no entry and reads zero
    always_comb begin
        rd_old_c = '0;
        rd_qry_c = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (32'(cl_q) == i) begin
                rd_old_c = tbl[i];
            end
            if (32'(qry_client) == i) begin
                rd_qry_c = tbl[i];
            end
        end
    end

    // Update value with saturation; clear wins over the amount
    always_comb begin
        cl_in_range_c = 32'(cl_q) < NUM_CLIENTS;
        sum_c         = SUM_W'(old_q) + SUM_W'(amt_q);
        ovf_c         = sum_c[CNT_W];
        if (clr_q) begin
            new_c = '0;
        end else if (ovf_c) begin
            new_c = '1;
        end else begin
            new_c = sum_c[CNT_W-1:0];
        end
        wr_en_c    = (state_q == WRITE) && cl_in_range_c;
        qry_next_c = (wr_en_c && (qry_client == cl_q)) ? new_c : rd_qry_c;
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                tbl[i] <= '0;
            end
            cl_q          <= '0;
            amt_q         <= '0;
            clr_q         <= 1'b0;
            old_q         <= '0;
            qry_cancelled <= '0;
            rpt_count     <= '0;
            sat_flag      <= 1'b0;
            err_flag      <= 1'b0;
        end else begin
            if (accept_c) begin
                cl_q      <= rpt_client;
                amt_q     <= rpt_amount;
                clr_q     <= rpt_clear;
                rpt_count <= rpt_count + 16'd1;
            end
            if (state_q == READ) begin
                old_q <= rd_old_c;
            end
            if (wr_en_c) begin
                for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                    if (32'(cl_q) == i) begin
                        tbl[i] <= new_c;
                    end
                end
                if (!clr_q && ovf_c) begin
                    sat_flag <= 1'b1;
                end
            end
            if ((state_q == WRITE) && !cl_in_range_c) begin
                err_flag <= 1'b1;
            end
            qry_cancelled <= qry_next_c;
        end
    end

endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// Directed scenarios plus randomized reports, checked every cycle against a
// transaction-level model of the client table.
module tb_downstream_cancel_tracker;

    localparam int unsigned NC = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          HRESETn;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [4:0]    rpt_client;
    logic [15:0]   rpt_amount;
    logic          rpt_clear;
    logic [4:0]    qry_client;
    logic [CW-1:0] qry_cancelled;
    logic [15:0]   rpt_count;
    logic          sat_flag;
    logic          err_flag;

    downstream_cancel_tracker #(.NUM_CLIENTS(NC), .CNT_W(CW)) dut (
        .clk           (clk),
        .HRESETn       (HRESETn),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_client    (rpt_client),
        .rpt_amount    (rpt_amount),
        .rpt_clear     (rpt_clear),
        .qry_client    (qry_client),
        .qry_cancelled (qry_cancelled),
        .rpt_count     (rpt_count),
        .sat_flag      (sat_flag),
        .err_flag      (err_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table contents plus one report in flight that commits two edges after acceptance
    int unsigned mtbl [32];
    int          busy;
    logic [4:0]  pc;
    logic [15:0] pa;
    logic        pclr;
    logic [15:0] mcount;
    logic        msat;
    logic        merr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mtbl[i] = 0;
        busy   = 0;
        mcount = '0;
        msat   = 1'b0;
        merr   = 1'b0;
    endtask

    function automatic int unsigned model_qry(input logic [4:0] c);
        return (int'(c) < NC) ? mtbl[c] : 0;
    endfunction

    task automatic model_commit();
        int unsigned s;
        if (int'(pc) >= NC) begin
            merr = 1'b1;
        end else if (pclr) begin
            mtbl[pc] = 0;
        end else begin
            s = mtbl[pc] + int'(pa);
            if (s > 65535) begin
                mtbl[pc] = 65535;
                msat     = 1'b1;
            end else begin
                mtbl[pc] = s;
            end
        end
    endtask

    // One clock with current inputs, then compare every output against the model
    task automatic step();
        bit acc;
        acc = rpt_valid && (busy == 0);
        @(posedge clk);
        #1;
        if (busy == 1) begin
            model_commit();
            busy = 0;
        end else if (busy == 2) begin
            busy = 1;
        end
        if (acc) begin
            pc     = rpt_client;
            pa     = rpt_amount;
            pclr   = rpt_clear;
            busy   = 2;
            mcount = mcount + 16'd1;
        end
        check_eq("ready", 32'(rpt_ready), 32'(busy == 0));
        check_eq("qry", 32'(qry_cancelled), model_qry(qry_client));
        check_eq("count", 32'(rpt_count), 32'(mcount));
        check_eq("sat", 32'(sat_flag), 32'(msat));
        check_eq("err", 32'(err_flag), 32'(merr));
    endtask

    task automatic send(input logic [4:0] c, input logic [15:0] a, input logic clr);
        int guard = 0;
        while (busy != 0 && guard < 10) begin
            rpt_valid = 1'b0;
            step();
            guard++;
        end
        rpt_valid  = 1'b1;
        rpt_client = c;
        rpt_amount = a;
        rpt_clear  = clr;
        step();
        rpt_valid = 1'b0;
        step();
        step();
    endtask

    // Asynchronous reset pulse with inputs left as they are
    task automatic apply_reset();
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_ready", 32'(rpt_ready), 32'd0);
        check_eq("rst_qry", 32'(qry_cancelled), 32'd0);
        check_eq("rst_count", 32'(rpt_count), 32'd0);
        check_eq("rst_sat", 32'(sat_flag), 32'd0);
        check_eq("rst_err", 32'(err_flag), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_ready", 32'(rpt_ready), 32'd0);
            check_eq("rst_hold_count", 32'(rpt_count), 32'd0);
        end
        HRESETn = 1'b1;
        #1;
        check_eq("rst_release_ready", 32'(rpt_ready), 32'd1);
    endtask

    initial begin
        HRESETn    = 1'b0;
        rpt_valid  = 1'b0;
        rpt_client = '0;
        rpt_amount = '0;
        rpt_clear  = 1'b0;
        qry_client = '0;
        model_reset();
        #3;
        apply_reset();

        // Two adds to client 3 with valid held across the busy window
        qry_client = 5'd3;
        rpt_valid  = 1'b1;
        rpt_client = 5'd3;
        rpt_amount = 16'd100;
        step();
        check_eq("busy_after_acc1", 32'(rpt_ready), 32'd0);
        rpt_amount = 16'd250;
        step();
        step();
        step();
        check_eq("busy_after_acc2", 32'(rpt_ready), 32'd0);
        rpt_valid = 1'b0;
        step();
        step();
        check_eq("add_350", 32'(qry_cancelled), 32'd350);
        check_eq("add_count", 32'(rpt_count), 32'd2);

        // Saturation on client 7
        qry_client = 5'd7;
        send(5'd7, 16'hFFF0, 1'b0);
        send(5'd7, 16'h0020, 1'b0);
        check_eq("sat_value", 32'(qry_cancelled), 32'h0000FFFF);
        check_eq("sat_flag", 32'(sat_flag), 32'd1);

        // Forwarding: query held on client 5 while its update is written
        qry_client = 5'd0;
        send(5'd5, 16'd40, 1'b0);
        qry_client = 5'd5;
        send(5'd5, 16'd10, 1'b0);
        check_eq("fwd_50", 32'(qry_cancelled), 32'd50);

        // Clear ignores the amount and leaves other clients alone
        qry_client = 5'd3;
        send(5'd3, 16'd55, 1'b1);
        check_eq("clear_3", 32'(qry_cancelled), 32'd0);
        qry_client = 5'd7;
        step();
        check_eq("clear_keeps_7", 32'(qry_cancelled), 32'h0000FFFF);
        check_eq("clear_keeps_sat", 32'(sat_flag), 32'd1);

        // Out-of-range client
        qry_client = 5'd20;
        send(5'd20, 16'd9, 1'b0);
        check_eq("oor_err", 32'(err_flag), 32'd1);
        check_eq("oor_count", 32'(rpt_count), 32'd8);
        check_eq("oor_qry", 32'(qry_cancelled), 32'd0);
        qry_client = 5'd5;
        step();
        check_eq("oor_keeps_5", 32'(qry_cancelled), 32'd50);

        // Reset while an add to client 1 sits in READ
        qry_client = 5'd1;
        rpt_valid  = 1'b1;
        rpt_client = 5'd1;
        rpt_amount = 16'd77;
        rpt_clear  = 1'b0;
        step();
        apply_reset();
        rpt_valid = 1'b0;
        step();
        check_eq("midop_tbl1", 32'(qry_cancelled), 32'd0);
        check_eq("midop_count", 32'(rpt_count), 32'd0);

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            rpt_valid  = ($urandom_range(0, 9) < 6);
            rpt_client = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            rpt_amount = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                                     : 16'($urandom_range(0, 2000));
            rpt_clear  = ($urandom_range(0, 9) == 0);
            qry_client = (busy != 0 && $urandom_range(0, 1) == 0) ? pc : 5'($urandom_range(0, 31));
            if (n % 1000 == 500) begin
                apply_reset();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/downstream_cancel_tracker.md
DOWNSTREAM_CANCEL_TRACKER -- requirements
Module: downstream_cancel_tracker

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 32, number of client table entries (1..32).
REQ-002 SHALL have parameter CNT_W, default 32, width of each cancelled-amount counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port HRESETn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port rpt_valid, input, 1, cancel/clear report present.
REQ-006 SHALL have port rpt_ready, output, 1, block can accept a report.
REQ-007 SHALL have port rpt_client, input, 5, client id of report.
REQ-008 SHALL have port rpt_amount, input, 16, cancelled quantity.
REQ-009 SHALL have port rpt_clear, input, 1, 1 = zero client counter, 0 = add rpt_amount.
REQ-010 SHALL have port qry_client, input, 5, client id queried by the upstream risk check.
REQ-011 SHALL have port qry_cancelled, output, CNT_W, cancelled total for qry_client.
REQ-012 SHALL have port rpt_count, output, 16, accepted-report counter.
REQ-013 SHALL have port sat_flag, output, 1, sticky counter-saturation indicator.
REQ-014 SHALL have port err_flag, output, 1, sticky out-of-range-client indicator.

Function
REQ-015 SHALL hold a table of NUM_CLIENTS counters, each CNT_W bits.
REQ-016 SHALL implement FSM states IDLE, READ, WRITE; IDLE->READ on handshake, READ->WRITE unconditionally, WRITE->IDLE unconditionally.
REQ-017 SHALL drive rpt_ready = 1 only in IDLE and only while HRESETn is high.
REQ-018 SHALL accept a report when rpt_valid && rpt_ready on a rising edge, latching client, amount, clear; inputs ignored at all other times.
REQ-019 In READ SHALL latch table[client]; in WRITE SHALL store the new value, visible in the table at the end of WRITE (2 cycles after acceptance); max throughput one report per 3 cycles.
REQ-020 Add: new = old + zero-extended rpt_amount; if the sum exceeds 2^CNT_W-1 SHALL store all-ones and set sat_flag.
REQ-021 Clear: new = 0, regardless of rpt_amount; sat_flag unaffected.
REQ-022 rpt_client >= NUM_CLIENTS SHALL still be accepted and sequenced through READ/WRITE but SHALL NOT modify any entry, and SHALL set err_flag.
REQ-023 rpt_count SHALL increment by 1 on every accepted report (including out-of-range), wrapping 16'hFFFF -> 0.
REQ-024 qry_cancelled SHALL be registered: value on cycle N+1 = table[qry_client sampled at N].
REQ-025 If the WRITE of cycle N targets the same client as qry_client at N, qry_cancelled at N+1 SHALL equal the newly written value (forwarding).
REQ-026 qry_client >= NUM_CLIENTS SHALL return 0 on qry_cancelled; err_flag unaffected.
REQ-027 sat_flag and err_flag SHALL remain set until reset.

Reset
REQ-028 HRESETn low SHALL immediately force FSM to IDLE, all table entries, qry_cancelled, rpt_count, sat_flag, err_flag to 0, rpt_ready to 0.
REQ-029 Reset asserted during READ or WRITE SHALL discard the in-flight report with no table update.
REQ-030 After HRESETn rises, rpt_ready SHALL be 1 on the first clock edge's following cycle, with no spurious acceptance during reset.

Verification
REQ-031 Add: client 3 adds 100 then 250 (valid held) -> table[3]=350, qry_client=3 reads 350, rpt_count=2, rpt_ready low 2 cycles after each accept.
REQ-032 Saturation (CNT_W=16): client 7 adds 0xFFF0 then 0x0020 -> qry_cancelled=0xFFFF, sat_flag=1.
REQ-033 Clear: client 3 at 350, clear report with amount 55 -> qry_cancelled=0; other entries unchanged.
REQ-034 Forwarding: qry_client=5 held while add of 10 to client 5 (old 40) is in WRITE -> qry_cancelled=50 next cycle, not 40.
REQ-035 Out-of-range (NUM_CLIENTS=16): report for client 20 amount 9 -> err_flag=1, rpt_count+1, no entry changes, query of 20 returns 0.
REQ-036 Reset mid-op: assert HRESETn low during READ of add 77 to client 1 -> table[1]=0, rpt_count=0, FSM IDLE, rpt_ready=1 after release.
